// File: rtl/dmux_sched_pkg.sv
// dmux_sched_pkg: shared state enum, sizes and reset constants for the dmux8 round-robin write scheduler
package dmux_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;
  localparam int NREQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;
  localparam logic [SEL_W-1:0] LAST_RST = 3'd7;
endpackage

// File: rtl/dmux8_rr_sched_if.sv
// dmux8_rr_sched_if: requester ports and demux/register-bank write path; master = requesters, slave = scheduler
interface dmux8_rr_sched_if
  import dmux_sched_pkg::*;
#(parameter int W = 16);
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ack;
  logic [SEL_W-1:0] load_sel;
  logic load_en;
  logic [W-1:0] wr_data;
  logic busy;
  modport master(output req, req_data, input grant, ack, load_sel, load_en, wr_data, busy);
  modport slave(input req, req_data, output grant, ack, load_sel, load_en, wr_data, busy);
endinterface

// File: rtl/rr_pick8.sv
// rr_pick8: combinational circular first-set search starting just above last
module rr_pick8
  import dmux_sched_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             any
);
  logic [SEL_W-1:0] idx;
  // scan farthest-first so the nearest set bit above last is the final assignment
  always_comb begin
    winner = '0;
    idx = '0;
    any = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = last + SEL_W'(i + 1);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/dmux8_rr_sched.sv
// dmux8_rr_sched: round-robin scheduler driving one 8-way load demux for HOLD cycles per transaction
// Optional: define DMUX_SCHED_PRIO0_EN to give requester 0 fixed top priority.
module dmux8_rr_sched
  import dmux_sched_pkg::*;
#(
  parameter int W = 16,
  parameter int HOLD = 1
) (
  input logic clk,
  input logic rst_n,
  dmux8_rr_sched_if.slave bus
);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [SEL_W-1:0] last, last_d, load_sel, sel_d, pick, win;
  logic [NREQ-1:0] grant, grant_d, ack, ack_d;
  logic [W-1:0] wr_data, data_d;
  logic load_en, en_d, any;
  rr_pick8 u_pick (.req(bus.req), .last(last), .winner(pick), .any(any));
`ifdef DMUX_SCHED_PRIO0_EN
  assign win = bus.req[0] ? '0 : pick;
`else
  assign win = pick;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last <= LAST_RST;
      grant <= '0;
      ack <= '0;
      load_sel <= '0;
      load_en <= 1'b0;
      wr_data <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      last <= last_d;
      grant <= grant_d;
      ack <= ack_d;
      load_sel <= sel_d;
      load_en <= en_d;
      wr_data <= data_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    last_d = last;
    grant_d = grant;
    sel_d = load_sel;
    data_d = wr_data;
    ack_d = '0;
    en_d = 1'b0;
    case (state)
      IDLE: begin
        grant_d = any ? NREQ'(1) << win : '0;
        sel_d = any ? win : '0;
        data_d = any ? bus.req_data[int'(win)*W +: W] : '0;
        cnt_d = CNT_W'(HOLD - 1);
        en_d = any;
        state_d = any ? LOAD : IDLE;
      end
      LOAD: begin
        en_d = cnt != '0;
        cnt_d = cnt != '0 ? cnt - 1'b1 : cnt;
        ack_d = cnt == '0 ? grant : '0;
        state_d = cnt == '0 ? ACK : LOAD;
      end
      default: begin
`ifdef DMUX_SCHED_PRIO0_EN
        last_d = load_sel == '0 ? last : load_sel;
`else
        last_d = load_sel;
`endif
        grant_d = '0;
        sel_d = '0;
        data_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  assign bus.grant = grant;
  assign bus.ack = ack;
  assign bus.load_sel = load_sel;
  assign bus.load_en = load_en;
  assign bus.wr_data = wr_data;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_dmux8_rr_sched.sv
// tb_dmux8_rr_sched: directed checks of the scheduler with HOLD=1 (u1) and HOLD=4 (u4)
module tb_dmux8_rr_sched;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  int n, ackc;
  logic [7:0] exp_g;
  dmux8_rr_sched_if #(.W(16)) b1 ();
  dmux8_rr_sched_if #(.W(16)) b4 ();
  dmux8_rr_sched #(.W(16), .HOLD(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  dmux8_rr_sched #(.W(16), .HOLD(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    b1.req = '0;
    b1.req_data = '0;
    b4.req = '0;
    b4.req_data = '0;
    tick();
    tick();
    chk("rst_grant", b1.grant, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_en", b1.load_en, 0);
    chk("rst_ack", b1.ack, 0);
    rst_n = 1'b1;
    b1.req = 8'h04;
    b1.req_data[2*16 +: 16] = 16'hBEEF;
    tick();
    chk("t1_sel", b1.load_sel, 2);
    chk("t1_en", b1.load_en, 1);
    chk("t1_data", b1.wr_data, 16'hBEEF);
    chk("t1_grant", b1.grant, 8'h04);
    chk("t1_ack_early", b1.ack, 0);
    tick();
    chk("t1_ack", b1.ack, 8'h04);
    chk("t1_en_off", b1.load_en, 0);
    chk("t1_grant_hold", b1.grant, 8'h04);
    b1.req = '0;
    tick();
    chk("t1_busy", b1.busy, 0);
    chk("t1_grant_clr", b1.grant, 0);
    chk("t1_ack_clr", b1.ack, 0);
    chk("t1_data_clr", b1.wr_data, 0);
    do_reset();
    for (int i = 0; i < 8; i++) b1.req_data[i*16 +: 16] = 16'hA000 + 16'(i);
    b1.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
`ifdef DMUX_SCHED_PRIO0_EN
      exp_g = 8'h01;
`else
      exp_g = 8'h01 << (k % 8);
`endif
      tick();
      chk("rr_grant", b1.grant, exp_g);
      chk("rr_data", b1.wr_data, 16'hA000 + 16'(b1.load_sel));
      tick();
      chk("rr_ack", b1.ack, exp_g);
      tick();
      chk("rr_gap", b1.busy, 0);
    end
    b1.req = '0;
    b4.req = 8'h20;
    b4.req_data[5*16 +: 16] = 16'h5555;
    n = 0;
    ackc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) chk("h4_sel", b4.load_sel, 5);
      if (b4.load_en) n++;
      if (b4.ack == 8'h20) begin
        ackc = c;
        b4.req = '0;
      end
    end
    chk("h4_en_cycles", n, 4);
    chk("h4_ack_cycle", ackc, 5);
    b4.req = 8'h08;
    b4.req_data[3*16 +: 16] = 16'h1234;
    tick();
    chk("drop_data1", b4.wr_data, 16'h1234);
    b4.req = '0;
    b4.req_data[3*16 +: 16] = 16'hFFFF;
    tick();
    tick();
    tick();
    chk("drop_data4", b4.wr_data, 16'h1234);
    chk("drop_en4", b4.load_en, 1);
    tick();
    chk("drop_ack", b4.ack, 8'h08);
    chk("drop_data_ack", b4.wr_data, 16'h1234);
    tick();
    b4.req = 8'h01;
    tick();
    tick();
    chk("mid_en", b4.load_en, 1);
    rst_n = 1'b0;
    b4.req = '0;
    tick();
    chk("mid_ack", b4.ack, 0);
    chk("mid_en_off", b4.load_en, 0);
    chk("mid_grant", b4.grant, 0);
    chk("mid_busy", b4.busy, 0);
    chk("mid_sel", b4.load_sel, 0);
    chk("mid_data", b4.wr_data, 0);
    rst_n = 1'b1;
    b4.req = 8'h81;
    tick();
    chk("post_grant0", b4.grant, 8'h01);
    tick();
    tick();
    tick();
    tick();
    chk("post_ack0", b4.ack, 8'h01);
    b4.req = 8'h80;
    tick();
    tick();
    chk("post_grant7", b4.grant, 8'h80);
    b4.req = '0;
    for (int c = 0; c < 5; c++) tick();
    do_reset();
    b1.req = 8'h03;
    for (int k = 0; k < 4; k++) begin
`ifdef DMUX_SCHED_PRIO0_EN
      exp_g = 8'h01;
`else
      exp_g = (k % 2) != 0 ? 8'h02 : 8'h01;
`endif
      tick();
      chk("pair_grant", b1.grant, exp_g);
      tick();
      tick();
    end
    b1.req = '0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmux8_rr_sched.md
# dmux8_rr_sched

Round-robin write scheduler that shares one 8-way load demultiplexer between eight requesters. It captures one requester's data and destination, then drives the demux select, the demux `din` (load enable) and a shared write-data bus to an 8-register bank for a programmable number of cycles. It returns a one-cycle acknowledge to the granted requester. It sits between the requester ports and the Dmux8way/register-bank datapath of the Hack memory subsystem.

## Interface
- `W`, 16, width of write data per requester.
- `HOLD`, 1, cycles `load_en` stays high per transaction; legal range 1..15.

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `req`  in  8  request per requester; held until that requester's `ack`.
- `req_data`  in  8*W  flattened data; requester i occupies bits [i*W +: W].
- `grant`  out  8  one-hot, the requester currently being served; 0 when idle.
- `ack`  out  8  one-hot, one-cycle pulse at transaction end.
- `load_sel`  out  3  demux select; equals index of granted requester.
- `load_en`  out  1  demux `din`; high exactly HOLD cycles per transaction.
- `wr_data`  out  W  captured data of granted requester.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, LOAD, ACK.
- IDLE: if `req` nonzero, pick winner = first set bit searching upward, circularly, from `last+1`. Register `grant`, `load_sel` and `wr_data = req_data[winner]`. Load counter with HOLD-1. Go to LOAD. If `req` is zero, stay in IDLE with all outputs 0.
- LOAD: `load_en`=1. Counter decrements each cycle. At counter 0, go to ACK.
- ACK: `load_en`=0. `ack[winner]`=1 for this cycle only. `last <= winner`. `grant` stays valid. Go to IDLE, and clear `grant`, `load_sel` and `wr_data` there.
- Data is captured once in IDLE. Changes on `req_data` during LOAD/ACK are ignored.
- Dropping `req[winner]` mid-transaction does not abort it; the transaction completes with `ack`.
- Requests arriving during LOAD/ACK wait; they are arbitrated in the next IDLE cycle.
- Requester must deassert `req` by the edge ending its `ack` cycle. A `req` still high in the following IDLE cycle is a new request.
- Fairness: a continuously requesting set is served in strict rotation; no requester waits more than 7 transactions.
- Reset: state IDLE, `last`=7 (requester 0 wins first), counter 0, all outputs 0. Reset mid-transaction aborts immediately: no `ack`, and `load_en` is 0 from the next cycle.

## Timing
- `req` sampled in IDLE cycle t. `grant`/`load_sel`/`wr_data` valid and `load_en` high from cycle t+1 through t+HOLD. `ack` is high at t+HOLD+1. IDLE resumes at t+HOLD+2.
- Throughput: one transaction per HOLD+2 cycles. Back-to-back grants have a one-cycle IDLE gap.
- `load_sel` and `wr_data` are stable for the entire LOAD and ACK window. There is no glitching on `load_en`; all outputs are registered.

## Configuration
- `DMUX_SCHED_PRIO0_EN` defined: requester 0 has fixed top priority. If `req[0]` is high in IDLE, it wins regardless of `last`, and `last` is not updated by requester-0 grants. The other seven rotate among themselves.
- Not defined: pure 8-way round-robin as described above. Requester 0 has no special treatment.

## Structure
- Shared package `dmux_sched_pkg` holds:
  - the state enum (IDLE, LOAD, ACK);
  - `NREQ=8`, `SEL_W=3`, `CNT_W=4`;
  - the reset value of `last` (7).
- Sub-module `rr_pick8`: purely combinational. Inputs are `req[7:0]` and `last[2:0]`. Outputs are `winner[2:0]` and `any`. It is instantiated once. The priority-0 override lives in the parent under the macro.

## Test plan
- Reset, then `req`=8'h04 with data 16'hBEEF, HOLD=1 → at t+1 `load_sel`=2, `load_en`=1, `wr_data`=16'hBEEF. At t+2 `ack`=8'h04. At t+3 `busy`=0.
- `req`=8'hFF held, acking each in turn → grant order 0,1,…,7,0; each `ack` is 3 cycles apart.
- HOLD=4, single request from requester 5 → `load_en` is high exactly 4 cycles; `ack[5]` follows in the next cycle.
- Requester 3 drops `req` and changes `req_data` during LOAD → transaction still completes with the originally captured data and `ack[3]`.
- `rst_n`=0 asserted in the second LOAD cycle → next cycle all outputs 0 and no `ack`. After release, `req`=8'h81 grants requester 0 first.
- With `DMUX_SCHED_PRIO0_EN`: `req`=8'h03 held → requester 0 is granted every transaction. With the macro undefined: grants alternate 0,1.
